load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 45 ++++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline-side and bus-side signals of the load/store unit in one bundle.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [31:0]       in_ir;
    logic [31:0]       in_alu;
    logic [31:0]       in_rs2;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_ir;
    logic [31:0]       out_wb_data;
    logic              out_wb_en;
    logic [4:0]        out_rd;
    logic [1:0]        out_exc;

    modport slave (
        input  in_valid, in_pc, in_ir, in_alu, in_rs2,
        input  mem_rdata, mem_ack, out_ready,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output out_valid, out_pc, out_ir, out_wb_data, out_wb_en, out_rd, out_exc
    );

    modport master (
        output in_valid, in_pc, in_ir, in_alu, in_rs2,
        output mem_rdata, mem_ack, out_ready,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  out_valid, out_pc, out_ir, out_wb_data, out_wb_en, out_rd, out_exc
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM stage: issues one aligned bus access per load/store, formats load data,
// and hands a registered result to writeback with an exception code.
//
// state | meaning
// IDLE  | ready to accept the next instruction from EX
// WAIT  | bus request outstanding, counting cycles until ack or timeout
// RESP  | result held on out_* until writeback takes it
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam int CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              ld_q;
    logic [2:0]        f3_q;
    logic [1:0]        ofs_q;
    logic [31:0]       pc_q, ir_q, wb_data_q;
    logic              wb_en_q;
    logic [4:0]        rd_q;
    logic [1:0]        exc_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        is_load, is_store, is_pass, f3_ok, misal, go_mem;
    logic [1:0]  acc_exc;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rd_shift, ld_val;
    logic        timeout_hit;

    always_comb begin
        opcode   = bus.in_ir[6:0];
        f3       = bus.in_ir[14:12];
        rd       = bus.in_ir[11:7];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_pass  = (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                   (opcode == OP_JAL) || (opcode == OP_JALR);
        f3_ok    = 1'b0;
        if (is_load)
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        else if (is_store)
            f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        misal = ((f3[1:0] == 2'b01) && bus.in_alu[0]) ||
                ((f3[1:0] == 2'b10) && (bus.in_alu[1:0] != 2'b00));
        acc_exc = 2'b00;
        if (is_load || is_store) begin
            if (!f3_ok)
                acc_exc = 2'b11;
            else if (misal)
                acc_exc = 2'b01;
        end
        go_mem = (is_load || is_store) && f3_ok && !misal;

        // Lanes only matter for stores; loads always read the full word.
        be_d    = 4'b1111;
        wdata_d = bus.in_rs2;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << bus.in_alu[1:0];
                    wdata_d = {4{bus.in_rs2[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << bus.in_alu[1:0];
                    wdata_d = {2{bus.in_rs2[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = bus.in_rs2;
                end
            endcase
        end
    end

    always_comb begin
        rd_shift = bus.mem_rdata >> {ofs_q, 3'b000};
        case (f3_q)
            3'b000:  ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_val = {24'd0, rd_shift[7:0]};
            3'b101:  ld_val = {16'd0, rd_shift[15:0]};
            default: ld_val = rd_shift;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TMO_LAST));

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = go_mem ? WAIT : RESP;
            WAIT: if (bus.mem_ack || timeout_hit) state_d = RESP;
            RESP: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ld_q      <= 1'b0;
            f3_q      <= '0;
            ofs_q     <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            rd_q      <= '0;
            exc_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    pc_q      <= bus.in_pc;
                    ir_q      <= bus.in_ir;
                    rd_q      <= rd;
                    exc_q     <= acc_exc;
                    wb_en_q   <= is_pass && (rd != 5'd0);
                    wb_data_q <= is_pass ? bus.in_alu : 32'd0;
                    addr_q    <= bus.in_alu[ADDR_W-1:0] & ~ADDR_W'(3);
                    be_q      <= be_d;
                    wdata_q   <= wdata_d;
                    we_q      <= is_store;
                    ld_q      <= is_load;
                    f3_q      <= f3;
                    ofs_q     <= bus.in_alu[1:0];
                    cnt_q     <= '0;
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        wb_en_q   <= ld_q && (rd_q != 5'd0);
                        wb_data_q <= ld_q ? ld_val : 32'd0;
                    end else if (timeout_hit) begin
                        exc_q   <= 2'b10;
                        wb_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request, strobe and enables exist only while the access is outstanding.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.mem_req     = (state_q == WAIT);
    assign bus.mem_we      = (state_q == WAIT) && we_q;
    assign bus.mem_be      = (state_q == WAIT) ? be_q : 4'b0000;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.out_valid   = (state_q == RESP);
    assign bus.out_pc      = pc_q;
    assign bus.out_ir      = ir_q;
    assign bus.out_wb_data = wb_data_q;
    assign bus.out_wb_en   = wb_en_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_exc     = exc_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases then random ops
// compared against a byte-lane level reference model.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom;
        return {r[31:15], f3, rd, op};
    endfunction

    // Issue one instruction, play the memory side, and check every visible output.
    task automatic do_op(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] rdata,
                         input int ack_at, input int ready_delay, input bit late_ack);
        logic [6:0]  op;
        int          f3, rd, size, off, bits;
        bit          ld, st, pass, legal, mis, mem, acked, exp_en;
        logic [1:0]  exp_exc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_wb;
        longint      val;

        op    = ir[6:0];
        f3    = int'(ir[14:12]);
        rd    = int'(ir[11:7]);
        ld    = (op == 7'b0000011);
        st    = (op == 7'b0100011);
        pass  = (op == 7'b0110111) || (op == 7'b0010111) ||
                (op == 7'b1101111) || (op == 7'b1100111);
        size  = ((f3 % 4) == 0) ? 1 : ((f3 % 4) == 1) ? 2 : 4;
        legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) :
                st ? (f3 <= 2) : 1'b1;
        off   = int'(alu[1:0]);
        mis   = (ld || st) && legal && ((off % size) != 0);
        mem   = (ld || st) && legal && !mis;
        exp_exc = !legal ? 2'b11 : mis ? 2'b01 : 2'b00;
        exp_be  = ld ? 4'hF : 4'(((1 << size) - 1) << off);
        exp_wd  = '0;
        for (int i = 0; i < 4; i++)
            exp_wd[8*i +: 8] = rs2[8*(i % size) +: 8];
        exp_en = 1'b0;
        exp_wb = alu;
        acked  = 1'b0;

        bus.in_pc    = pc;
        bus.in_ir    = ir;
        bus.in_alu   = alu;
        bus.in_rs2   = rs2;
        bus.in_valid = 1'b1;
        chk("in_ready_idle", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_pc    = $urandom;
        bus.in_ir    = $urandom;
        bus.in_alu   = $urandom;
        bus.in_rs2   = $urandom;

        if (mem) begin
            for (int w = 0; w < TMO; w++) begin
                chk("mem_req_wait", bus.mem_req, 1);
                chk("mem_addr", bus.mem_addr, alu & ~32'd3);
                chk("mem_we", bus.mem_we, st);
                chk("mem_be", bus.mem_be, exp_be);
                if (st) chk("mem_wdata", bus.mem_wdata, exp_wd);
                chk("out_valid_wait", bus.out_valid, 0);
                chk("in_ready_wait", bus.in_ready, 0);
                if (w == ack_at) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                    tick();
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    acked = 1'b1;
                    break;
                end
                tick();
            end
            if (!acked) exp_exc = 2'b10;
            bits = 8 * size;
            val  = longint'(rdata >> (8 * off));
            if (bits < 32) begin
                val = val & ((longint'(1) << bits) - 1);
                if (f3 < 4 && val[bits-1]) val = val - (longint'(1) << bits);
            end
            exp_wb = val[31:0];
            exp_en = ld && acked && (rd != 0);
        end else begin
            exp_en = pass && (rd != 0);
        end
        chk("mem_req_resp", bus.mem_req, 0);

        for (int c = 0; c <= ready_delay; c++) begin
            if (c == ready_delay) bus.out_ready = 1'b1;
            if (late_ack && c == 0) bus.mem_ack = 1'b1;
            chk("out_valid", bus.out_valid, 1);
            chk("in_ready_resp", bus.in_ready, 0);
            chk("out_pc", bus.out_pc, pc);
            chk("out_ir", bus.out_ir, ir);
            chk("out_rd", bus.out_rd, 32'(rd));
            chk("out_exc", bus.out_exc, exp_exc);
            chk("out_wb_en", bus.out_wb_en, exp_en);
            if (exp_en || pass) chk("out_wb_data", bus.out_wb_data, exp_wb);
            tick();
            bus.mem_ack = 1'b0;
        end
        bus.out_ready = 1'b0;
        chk("out_valid_done", bus.out_valid, 0);
        chk("in_ready_done", bus.in_ready, 1);
        chk("mem_req_done", bus.mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] alu;
        int sel;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_ir     = '0;
        bus.in_alu    = '0;
        bus.in_rs2    = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_wb_en", bus.out_wb_en, 0);
        chk("rst_out_wb_data", bus.out_wb_data, 0);
        chk("rst_out_exc", bus.out_exc, 0);
        chk("rst_out_pc", bus.out_pc, 0);

        // LB at byte 3 of word 0x100, ack after 3 wait cycles
        do_op(32'h0000_1000, mk_ir(7'b0000011, 3'b000, 5'd7), 32'h0000_0103, 32'h0,
              32'h80FF_1234, 3, 0, 0);
        chk("lb_fixed_value", bus.out_wb_data, 32'hFFFF_FF80);
        // SH to upper half
        do_op(32'h0000_1004, mk_ir(7'b0100011, 3'b001, 5'd0), 32'h0000_0022, 32'hDEAD_BEEF,
              32'h0, 1, 0, 0);
        // Misaligned LW
        do_op(32'h0000_1008, mk_ir(7'b0000011, 3'b010, 5'd3), 32'h0000_0006, 32'h0,
              32'h0, 0, 0, 0);
        // LW with no ack: timeout, then a late ack in RESP
        do_op(32'h0000_100C, mk_ir(7'b0000011, 3'b010, 5'd4), 32'h0000_0040, 32'h0,
              32'h1234_5678, 99, 1, 1);
        // JAL held while out_ready stays low
        do_op(32'h0000_1010, mk_ir(7'b1101111, 3'b000, 5'd5), 32'h0000_0044, 32'h0,
              32'h0, 0, 3, 0);
        // Illegal load funct3
        do_op(32'h0000_1014, mk_ir(7'b0000011, 3'b011, 5'd6), 32'h0000_0010, 32'h0,
              32'h0, 0, 0, 0);

        // Reset in the middle of a wait, then a stray ack
        bus.in_ir    = mk_ir(7'b0000011, 3'b010, 5'd9);
        bus.in_alu   = 32'h0000_0080;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rstw_mem_req_before", bus.mem_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_mem_req", bus.mem_req, 0);
        chk("rstw_mem_be", bus.mem_be, 0);
        chk("rstw_in_ready", bus.in_ready, 1);
        chk("rstw_out_exc", bus.out_exc, 0);
        chk("rstw_out_wb_data", bus.out_wb_data, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_out_valid", bus.out_valid, 0);
        chk("stray_ack_mem_req", bus.mem_req, 0);
        chk("stray_ack_in_ready", bus.in_ready, 1);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 4) begin
                op = 7'b0000011;
                f3 = 3'($urandom_range(0, 7));
            end else if (sel <= 8) begin
                op = 7'b0100011;
                f3 = 3'($urandom_range(0, 3));
            end else if (sel == 9) begin
                case ($urandom_range(0, 3))
                    0: op = 7'b0110111;
                    1: op = 7'b0010111;
                    2: op = 7'b1101111;
                    default: op = 7'b1100111;
                endcase
                f3 = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 3))
                    0: op = 7'b0110011;
                    1: op = 7'b0010011;
                    2: op = 7'b1110011;
                    default: op = 7'b1100011;
                endcase
                f3 = 3'($urandom_range(0, 7));
            end
            alu = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            do_op($urandom, mk_ir(op, f3, 5'($urandom_range(0, 31))), alu, $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
